// File: rtl/rx_bit_unstuffer.sv
// NRZI decoder and bit unstuffer for the full-speed receive path.
// Drops stuffed zeros, flags stuffing violations, assembles bytes LSB-first.
module rx_bit_unstuffer #(
   parameter int unsigned STUFF_LEN = 6
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       rcving,
   input  logic       bit_strobe,
   input  logic       d_line,
   input  logic       eop,
   output logic       d_decoded,
   output logic       bit_valid,
   output logic       stuff_skip,
   output logic       stuff_error,
   output logic [2:0] ones_count,
   output logic [2:0] bit_index,
   output logic [7:0] rx_byte,
   output logic       byte_ready
);

   localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN);

   logic prev_line;
   logic dec;
   logic stuff_slot;

   assign dec        = (d_line == prev_line);
   assign stuff_slot = (ones_count == STUFF_MAX);

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_line   <= 1'b1;
         d_decoded   <= 1'b1;
         bit_valid   <= 1'b0;
         stuff_skip  <= 1'b0;
         stuff_error <= 1'b0;
         byte_ready  <= 1'b0;
         ones_count  <= 3'd0;
         bit_index   <= 3'd0;
         rx_byte     <= 8'h00;
      end else begin
         bit_valid  <= 1'b0;
         stuff_skip <= 1'b0;
         byte_ready <= 1'b0;
         if (!rcving) begin
            prev_line   <= 1'b1;
            d_decoded   <= 1'b1;
            stuff_error <= 1'b0;
            ones_count  <= 3'd0;
            bit_index   <= 3'd0;
            rx_byte     <= 8'h00;
         end else if (bit_strobe) begin
            if (eop) begin
               // rx_byte deliberately keeps the last partial/complete byte
               ones_count <= 3'd0;
               bit_index  <= 3'd0;
               prev_line  <= 1'b1;
            end else begin
               prev_line <= d_line;
               d_decoded <= dec;
               if (stuff_slot) begin
                  if (dec) begin
                     stuff_error <= 1'b1;
                  end else begin
                     stuff_skip <= 1'b1;
                     ones_count <= 3'd0;
                  end
               end else begin
                  bit_valid  <= 1'b1;
                  rx_byte    <= {dec, rx_byte[7:1]};
                  ones_count <= dec ? ones_count + 3'd1 : 3'd0;
                  bit_index  <= bit_index + 3'd1;
                  byte_ready <= (bit_index == 3'd7);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rx_bit_unstuffer.sv
// Bench for rx_bit_unstuffer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized line traffic.
module tb_rx_bit_unstuffer;
   localparam int STUFF_LEN = 6;

   logic       clk = 1'b0;
   logic       n_rst = 1'b1;
   logic       rcving = 1'b0;
   logic       bit_strobe = 1'b0;
   logic       d_line = 1'b1;
   logic       eop = 1'b0;
   logic       d_decoded, bit_valid, stuff_skip, stuff_error, byte_ready;
   logic [2:0] ones_count, bit_index;
   logic [7:0] rx_byte;

   rx_bit_unstuffer #(.STUFF_LEN(STUFF_LEN)) dut (
      .clk(clk), .n_rst(n_rst), .rcving(rcving), .bit_strobe(bit_strobe),
      .d_line(d_line), .eop(eop), .d_decoded(d_decoded), .bit_valid(bit_valid),
      .stuff_skip(stuff_skip), .stuff_error(stuff_error), .ones_count(ones_count),
      .bit_index(bit_index), .rx_byte(rx_byte), .byte_ready(byte_ready)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   int bv_cnt = 0;
   int br_cnt = 0;

   // reference model state: data-bit history since the last clear, run length, bits in byte
   bit   hist[$];
   logic m_prev = 1'b1;
   logic m_dec = 1'b1;
   logic m_bv = 1'b0, m_skip = 1'b0, m_err = 1'b0, m_br = 1'b0;
   int   m_run = 0;
   int   m_nbits = 0;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_byte();
      logic [7:0] b;
      b = 8'h00;
      for (int k = 0; k < 8; k++) b[k] = hist[hist.size() - 8 + k];
      return b;
   endfunction

   task automatic model_clear();
      hist.delete();
      for (int k = 0; k < 8; k++) hist.push_back(1'b0);
      m_prev = 1'b1; m_dec = 1'b1; m_bv = 1'b0; m_skip = 1'b0;
      m_err = 1'b0; m_br = 1'b0; m_run = 0; m_nbits = 0;
   endtask

   always @(posedge clk or negedge n_rst) begin
      bit dec;
      if (!n_rst) begin
         model_clear();
      end else begin
         m_bv = 1'b0; m_skip = 1'b0; m_br = 1'b0;
         if (!rcving) begin
            model_clear();
         end else if (bit_strobe) begin
            if (eop) begin
               m_run = 0; m_nbits = 0; m_prev = 1'b1;
            end else begin
               dec = (d_line == m_prev);
               m_prev = d_line;
               m_dec = dec;
               if (m_run == STUFF_LEN) begin
                  if (dec) m_err = 1'b1;
                  else begin m_skip = 1'b1; m_run = 0; end
               end else begin
                  m_bv = 1'b1;
                  m_run = dec ? m_run + 1 : 0;
                  hist.push_back(dec);
                  void'(hist.pop_front());
                  m_nbits++;
                  m_br = (m_nbits % 8 == 0);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("d_decoded", d_decoded, m_dec);
         check("bit_valid", bit_valid, m_bv);
         check("stuff_skip", stuff_skip, m_skip);
         check("stuff_error", stuff_error, m_err);
         check("ones_count", ones_count, 8'(m_run));
         check("bit_index", bit_index, 8'(m_nbits % 8));
         check("rx_byte", rx_byte, model_byte());
         check("byte_ready", byte_ready, m_br);
         if (bit_valid) bv_cnt++;
         if (byte_ready) br_cnt++;
      end
   end

   // caller sits just after a falling edge; returns just after the next one
   task automatic strobe(input logic line, input logic e);
      d_line = line; eop = e; bit_strobe = 1'b1;
      @(negedge clk); #1;
      bit_strobe = 1'b0; eop = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic clear_rx();
      rcving = 1'b0;
      idle(1);
      rcving = 1'b1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_d_decoded"}, d_decoded, 1'b1);
      check({tag, "_bit_valid"}, bit_valid, 1'b0);
      check({tag, "_stuff_error"}, stuff_error, 1'b0);
      check({tag, "_ones"}, ones_count, 3'd0);
      check({tag, "_bit_index"}, bit_index, 3'd0);
      check({tag, "_rx_byte"}, rx_byte, 8'h00);
      check({tag, "_byte_ready"}, byte_ready, 1'b0);
   endtask

   logic [7:0] seq_a5;
   logic [7:0] prev_rnd;

   initial begin
      #1 n_rst = 1'b0;
      #1 chk_en = 1'b1;
      idle(2);
      check_reset_vals("reset");
      n_rst = 1'b1;
      rcving = 1'b1;
      idle(1);

      // alternating line: every decoded bit is zero
      bv_cnt = 0; br_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         strobe(logic'(i % 2), 1'b0);
         check("alt_dec", d_decoded, 1'b0);
      end
      check("alt_bv_cnt", 8'(bv_cnt), 8'd8);
      check("alt_br_cnt", 8'(br_cnt), 8'd1);
      check("alt_byte_ready", byte_ready, 1'b1);
      check("alt_rx_byte", rx_byte, 8'h00);
      check("alt_ones", ones_count, 3'd0);

      // 1,0,0,1,0,0,1,1 decodes to A5
      clear_rx();
      seq_a5 = 8'b1100_1001;
      br_cnt = 0;
      for (int i = 0; i < 8; i++) strobe(seq_a5[i], 1'b0);
      check("a5_model", model_byte(), 8'hA5);
      check("a5_rx_byte", rx_byte, 8'hA5);
      check("a5_byte_ready", byte_ready, 1'b1);
      check("a5_br_cnt", 8'(br_cnt), 8'd1);
      check("a5_bit_index", bit_index, 3'd0);
      check("a5_ones", ones_count, 3'd1);

      // six ones then a stuffed zero
      clear_rx();
      bv_cnt = 0;
      for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);
      check("stf_bv_cnt", 8'(bv_cnt), 8'd6);
      check("stf_ones6", ones_count, 3'd6);
      check("stf_model_run", 8'(m_run), 8'd6);
      strobe(1'b0, 1'b0);
      check("stf_skip", stuff_skip, 1'b1);
      check("stf_no_bv", bit_valid, 1'b0);
      check("stf_ones0", ones_count, 3'd0);
      check("stf_bit_index", bit_index, 3'd6);
      check("stf_bv_cnt2", 8'(bv_cnt), 8'd6);

      // seven ones: stuffing violation, sticky until rcving drops
      clear_rx();
      for (int i = 0; i < 7; i++) strobe(1'b1, 1'b0);
      check("err_model", m_err, 1'b1);
      check("err_set", stuff_error, 1'b1);
      check("err_ones", ones_count, 3'd6);
      check("err_no_bv", bit_valid, 1'b0);
      strobe(1'b1, 1'b0);
      strobe(1'b0, 1'b0);
      idle(2);
      check("err_sticky", stuff_error, 1'b1);
      clear_rx();
      check("err_cleared", stuff_error, 1'b0);
      check("err_clr_ones", ones_count, 3'd0);

      // stuffed zero straddling a byte boundary
      clear_rx();
      br_cnt = 0;
      strobe(1'b0, 1'b0);
      strobe(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) strobe(1'b1, 1'b0);
      check("bnd_byte_ready", byte_ready, 1'b1);
      check("bnd_rx_byte", rx_byte, 8'hFC);
      check("bnd_ones", ones_count, 3'd6);
      strobe(1'b0, 1'b0);
      check("bnd_skip", stuff_skip, 1'b1);
      check("bnd_no_br", byte_ready, 1'b0);
      check("bnd_bit_index", bit_index, 3'd0);
      strobe(1'b0, 1'b0);
      check("bnd_next_bv", bit_valid, 1'b1);
      check("bnd_next_idx", bit_index, 3'd1);
      check("bnd_br_cnt", 8'(br_cnt), 8'd1);

      // EOP mid-byte, then rcving drop, then async reset
      clear_rx();
      seq_a5 = 8'b0000_1001;
      for (int i = 0; i < 4; i++) strobe(seq_a5[i], 1'b0);
      check("eop_pre_idx", bit_index, 3'd4);
      strobe(1'b0, 1'b1);
      check("eop_bit_index", bit_index, 3'd0);
      check("eop_ones", ones_count, 3'd0);
      check("eop_no_br", byte_ready, 1'b0);
      check("eop_no_bv", bit_valid, 1'b0);
      check("eop_rx_hold", rx_byte, 8'h50);
      for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
      clear_rx();
      check_reset_vals("rcv_drop");
      for (int i = 0; i < 3; i++) strobe(1'b1, 1'b0);
      #2 n_rst = 1'b0;
      #1 check_reset_vals("async_rst");
      @(negedge clk); #3 n_rst = 1'b1;
      idle(1);
      check_reset_vals("post_rst");

      // randomized traffic: runs of ones are favoured so stuff slots and errors occur
      prev_rnd = 8'h01;
      for (int i = 0; i < 3000; i++) begin
         int r;
         logic line;
         r = int'($urandom_range(0, 199));
         line = ($urandom_range(0, 3) != 0) ? prev_rnd[0] : ~prev_rnd[0];
         prev_rnd[0] = line;
         if (r < 2) begin
            rcving = 1'b0;
            bit_strobe = ($urandom_range(0, 1) == 1);
            d_line = line;
            idle(1);
            bit_strobe = 1'b0;
            rcving = 1'b1;
            prev_rnd[0] = 1'b1;
         end else if (r < 7) begin
            strobe(line, 1'b1);
            prev_rnd[0] = 1'b1;
         end else begin
            strobe(line, 1'b0);
         end
         idle(int'($urandom_range(0, 2)));
      end

      idle(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rx_bit_unstuffer.md
Name: rx_bit_unstuffer

Overview:
Receive-side counterpart of the TX bit-stuff path in the USB full-speed transceiver.
- Takes the sampled line level once per bit strobe and NRZI-decodes it.
- Detects and drops stuffed zeros after STUFF_LEN consecutive ones, and flags stuffing violations.
- Assembles surviving data bits LSB-first into bytes for the RX packet controller.
- Sits between the edge/bit-strobe detector and the RX control FSM.

Parameters:
STUFF_LEN, 6, number of consecutive decoded ones after which the next bit must be a stuffed zero (legal range 2..7).

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
rcving  input  1  high while a packet is being received; low synchronously clears all receive state
bit_strobe  input  1  one-cycle pulse at mid-bit sample point
d_line  input  1  sampled D+ level (J=1, K=0), valid when bit_strobe=1
eop  input  1  SE0/EOP detected; qualified by bit_strobe
d_decoded  output  1  last NRZI-decoded bit
bit_valid  output  1  one-cycle pulse: d_decoded is a data bit
stuff_skip  output  1  one-cycle pulse: a stuffed zero was dropped
stuff_error  output  1  sticky: a one arrived where a stuffed zero was required
ones_count  output  3  current run of consecutive decoded ones
bit_index  output  3  position of next data bit within the byte
rx_byte  output  8  assembled byte, LSB received first
byte_ready  output  1  one-cycle pulse: rx_byte holds a complete byte

Behaviour:
- Reset (n_rst=0, async):
  - prev_line=1; d_decoded=1.
  - bit_valid, stuff_skip, stuff_error, byte_ready = 0.
  - ones_count=0, bit_index=0, rx_byte=8'h00.
- All outputs are registered. Pulses appear in the cycle after the strobe cycle, i.e. latency 1 clk.
- Without bit_strobe, all state holds, and bit_valid, stuff_skip and byte_ready are 0.
- NRZI decode: dec = (d_line == prev_line) ? 1 : 0. prev_line <= d_line on every processed strobe.
- Priority per cycle: rcving=0 > eop > stuff slot > normal data.
- rcving=0 (any cycle, strobe or not):
  - Synchronous clear to the reset values above, including the sticky stuff_error.
  - Dropping rcving mid-byte discards the partial byte; no byte_ready.
- eop & bit_strobe:
  - ones_count=0, bit_index=0, prev_line=1.
  - No bit_valid, no byte_ready.
  - rx_byte holds its last value.
- Stuff slot (bit_strobe, ones_count==STUFF_LEN):
  - dec=0: stuff_skip=1, ones_count=0. Bit not shifted; bit_index unchanged.
  - dec=1: stuff_error=1 (sticky), ones_count stays at STUFF_LEN (saturates), bit dropped, no bit_valid.
- Normal data (bit_strobe, ones_count<STUFF_LEN):
  - bit_valid=1, d_decoded=dec.
  - rx_byte <= {dec, rx_byte[7:1]}.
  - ones_count <= dec ? ones_count+1 : 0.
  - bit_index increments mod 8.
  - When bit_index was 7, byte_ready=1 in the same cycle rx_byte shows the full byte, and bit_index wraps to 0.
- A stuffed bit may fall at a byte boundary: the skip occurs before the next byte's bit 0, and byte_ready is unaffected.
- The ones run spans byte boundaries; ones_count is not reset at byte_ready.
- ones_count never exceeds STUFF_LEN.

Test Plan:
- Reset, rcving=1, d_line alternating 0,1,0,1,0,1,0,1 over 8 strobes -> eight bit_valid pulses, dec all 0, byte_ready once, rx_byte=8'h00, ones_count=0.
- d_line sequence 1,0,0,1,0,0,1,1 from idle -> rx_byte=8'hA5, byte_ready one cycle after the 8th strobe, bit_index=0.
- d_line held 1 for 6 strobes then 0 -> 6 bit_valid pulses, ones_count=6, then stuff_skip=1, ones_count=0, bit_index=6, no 7th bit_valid.
- d_line held 1 for 7 strobes -> after the 7th strobe stuff_error=1, ones_count=6; stuff_error stays set until rcving=0, then clears with all state.
- After 4 data bits, assert eop with strobe -> bit_index=0, ones_count=0, no byte_ready. Then drop rcving mid-byte, and separately pulse n_rst mid-byte (async) -> all outputs return to reset values.
